ring_phase_monitor: RTL and testbench

//  Downstream consumer of the 3-stage one-hot ring counter output (qc).
//  - Samples the ring vector each enabled cycle and encodes the hot bit to a binary phase index.
//  - Checks that each new sample is exactly one step of rotation from the last.
//  - Counts complete revolutions.
//  - Flags non-one-hot and out-of-sequence patterns with sticky errors, for the sequencer and debug logic.

---
 rtl/ring_mon_pkg.sv | 31 +++
 rtl/onehot_to_bin.sv | 21 ++
 rtl/ring_phase_monitor.sv | 94 +++++++++
 tb/tb_ring_phase_monitor.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ring_mon_pkg.sv
// Shared types and helpers for the ring phase monitor: FSM state encoding,
// one-step ring rotation and one-hot test on a width-capped vector.
package ring_mon_pkg;

  localparam int unsigned RING_MAX_W  = 32;
  localparam int unsigned RING_MAX_IW = $clog2(RING_MAX_W);

  typedef enum logic [1:0] {
    SYNC,
    TRACK,
    FAULT
  } ring_mon_state_t;

  // Rotates the low n bits of vec left by one (bit i -> i+1, bit n-1 -> 0).
  function automatic logic [RING_MAX_W-1:0] rotl1(input logic [RING_MAX_W-1:0] vec,
                                                  input int unsigned n);
    logic [RING_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < RING_MAX_W; i++) begin
      if (i < n) begin
        r[RING_MAX_IW'((i + 1) % n)] = vec[RING_MAX_IW'(i)];
      end
    end
    return r;
  endfunction

  function automatic logic is_onehot(input logic [RING_MAX_W-1:0] vec);
    return (vec != '0) && ((vec & (vec - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// Combinational one-hot to binary encoder; non-one-hot inputs give the OR of
// the set bit indices and are screened out by the caller.
module onehot_to_bin #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]         vec,
  output logic [$clog2(N)-1:0] bin
);

  localparam int unsigned IDX_W = $clog2(N);

  always_comb begin
    bin = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i]) begin
        bin = bin | IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/ring_phase_monitor.sv
// Tracks a one-hot ring counter: encodes phase, checks rotation order, counts
// revolutions, flags sticky errors. Define RING_MON_REV_SAT_EN to saturate rev_count.
module ring_phase_monitor
  import ring_mon_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned REV_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [N-1:0]         ring_in,
  input  logic                 clr_err,
  output logic [$clog2(N)-1:0] phase_idx,
  output logic                 phase_valid,
  output logic                 rev_tick,
  output logic [REV_W-1:0]     rev_count,
  output logic                 err_onehot,
  output logic                 err_seq
);

  localparam int unsigned IDX_W = $clog2(N);

  ring_mon_state_t  state;
  logic [N-1:0]     prev;
  logic [IDX_W-1:0] in_idx;
  logic             in_onehot;
  logic             in_next;
  logic             sample;
  logic             bad_onehot;
  logic             bad_seq;
  logic [REV_W-1:0] rev_next;

  onehot_to_bin #(.N(N)) u_enc (
    .vec (ring_in),
    .bin (in_idx)
  );

  always_comb begin
    in_onehot  = is_onehot(RING_MAX_W'(ring_in));
    in_next    = (ring_in == N'(rotl1(RING_MAX_W'(prev), N)));
    sample     = en && (state != FAULT);
    bad_onehot = sample && !in_onehot;
    bad_seq    = sample && in_onehot && (state == TRACK) && !in_next;
`ifdef RING_MON_REV_SAT_EN
    rev_next   = (rev_count == '1) ? rev_count : rev_count + 1'b1;
`else
    rev_next   = rev_count + 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SYNC;
      prev        <= '0;
      phase_idx   <= '0;
      phase_valid <= 1'b0;
      rev_tick    <= 1'b0;
      rev_count   <= '0;
      err_onehot  <= 1'b0;
      err_seq     <= 1'b0;
    end else begin
      rev_tick <= 1'b0;
      if (clr_err) begin
        // Clear and a same-cycle detection: the new error survives the clear.
        err_onehot  <= bad_onehot;
        err_seq     <= bad_seq;
        rev_count   <= '0;
        phase_valid <= 1'b0;
        state       <= SYNC;
      end else if (sample) begin
        if (bad_onehot || bad_seq) begin
          err_onehot <= err_onehot | bad_onehot;
          err_seq    <= err_seq | bad_seq;
          if (state == TRACK) begin
            phase_valid <= 1'b0;
            state       <= FAULT;
          end
        end else begin
          prev        <= ring_in;
          phase_idx   <= in_idx;
          phase_valid <= 1'b1;
          state       <= TRACK;
          // A legal step landing on phase 0 can only have come from N-1.
          if (state == TRACK && ring_in[0]) begin
            rev_tick  <= 1'b1;
            rev_count <= rev_next;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Self-checking bench for ring_phase_monitor (N=3, REV_W=2) against a phase-index reference model.
module tb_ring_phase_monitor;

  localparam int unsigned N     = 3;
  localparam int unsigned REV_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [N-1:0]     ring_in;
  logic             clr_err;
  logic [1:0]       phase_idx;
  logic             phase_valid;
  logic             rev_tick;
  logic [REV_W-1:0] rev_count;
  logic             err_onehot;
  logic             err_seq;

  ring_phase_monitor #(.N(N), .REV_W(REV_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .ring_in     (ring_in),
    .clr_err     (clr_err),
    .phase_idx   (phase_idx),
    .phase_valid (phase_valid),
    .rev_tick    (rev_tick),
    .rev_count   (rev_count),
    .err_onehot  (err_onehot),
    .err_seq     (err_seq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 = waiting for sync, 1 = tracking, 2 = faulted.
  int m_mode = 0;
  int m_idx  = 0;
  int m_valid = 0;
  int m_tick = 0;
  int m_cnt  = 0;
  int m_eo   = 0;
  int m_es   = 0;
  int tick_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int ones, hot, new_eo, new_es, good;
    if (reset) begin
      m_mode = 0; m_idx = 0; m_valid = 0; m_tick = 0; m_cnt = 0; m_eo = 0; m_es = 0;
      return;
    end
    m_tick = 0;
    ones = $countones(ring_in);
    hot = 0;
    for (int i = 0; i < N; i++) if (ring_in[i]) hot = i;
    new_eo = 0; new_es = 0; good = 0;
    if (en && m_mode != 2) begin
      if (ones != 1) new_eo = 1;
      else if (m_mode == 1 && hot != (m_idx + 1) % N) new_es = 1;
      else good = 1;
    end
    if (clr_err) begin
      m_eo = new_eo; m_es = new_es; m_cnt = 0; m_valid = 0; m_mode = 0;
    end else if (new_eo || new_es) begin
      m_eo = m_eo | new_eo;
      m_es = m_es | new_es;
      if (m_mode == 1) begin m_valid = 0; m_mode = 2; end
    end else if (good) begin
      if (m_mode == 1 && hot == 0) begin
        m_tick = 1;
`ifdef RING_MON_REV_SAT_EN
        m_cnt = (m_cnt == (1 << REV_W) - 1) ? m_cnt : m_cnt + 1;
`else
        m_cnt = (m_cnt + 1) % (1 << REV_W);
`endif
      end
      m_idx = hot; m_valid = 1; m_mode = 1;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [N-1:0] rin, input logic c);
    @(negedge clk);
    reset = r; en = e; ring_in = rin; clr_err = c;
    @(posedge clk);
    model_step();
    #1;
    if (rev_tick === 1'b1) tick_seen++;
    check("phase_idx",   32'(phase_idx),   32'(m_idx));
    check("phase_valid", 32'(phase_valid), 32'(m_valid));
    check("rev_tick",    32'(rev_tick),    32'(m_tick));
    check("rev_count",   32'(rev_count),   32'(m_cnt));
    check("err_onehot",  32'(err_onehot),  32'(m_eo));
    check("err_seq",     32'(err_seq),     32'(m_es));
  endtask

  int exp_rev[5];
  logic [N-1:0] cur;
  logic [N-1:0] nxt;

  initial begin
    reset = 1'b1; en = 1'b0; ring_in = '0; clr_err = 1'b0;

    // 1: reset held two cycles, all outputs zero
    step(1, 0, 3'b000, 0);
    step(1, 1, 3'b011, 1);
    check("reset_all_zero", {phase_idx, phase_valid, rev_tick, rev_count, err_onehot, err_seq}, 32'd0);

    // 2: clean rotation with one revolution
    step(0, 1, 3'b001, 0);
    step(0, 1, 3'b010, 0);
    step(0, 1, 3'b100, 0);
    step(0, 1, 3'b001, 0);
    check("rev_tick_on_wrap", 32'(rev_tick), 32'd1);
    step(0, 1, 3'b010, 0);
    check("rev_count_one", 32'(rev_count), 32'd1);
    check("idx_one", 32'(phase_idx), 32'd1);

    // reset mid-TRACK discards tracking
    step(1, 1, 3'b100, 0);
    check("reset_midtrack", {phase_idx, phase_valid, rev_count}, 32'd0);

    // 3: non-one-hot in TRACK, later samples ignored
    step(0, 1, 3'b001, 0);
    step(0, 1, 3'b010, 0);
    step(0, 1, 3'b011, 0);
    step(0, 1, 3'b100, 0);
    step(0, 1, 3'b001, 0);
    check("onehot_err", {30'd0, err_onehot, phase_valid}, 32'd2);
    check("idx_held", 32'(phase_idx), 32'd1);

    // 4: sequence error, then clear and resync at phase 2
    step(0, 1, 3'b000, 1);
    step(0, 1, 3'b001, 0);
    step(0, 1, 3'b100, 0);
    check("seq_err", 32'(err_seq), 32'd1);
    step(0, 0, 3'b000, 1);
    check("clr_err", {err_onehot, err_seq, rev_count, phase_valid}, 32'd0);
    step(0, 1, 3'b100, 0);
    check("resync_idx2", {30'd0, phase_idx}, 32'd2);

    // clear with simultaneous detection: set wins
    step(0, 1, 3'b110, 1);
    check("clr_set_wins", {30'd0, err_onehot, phase_valid}, 32'd2);

    // 5: en gating skips samples
    step(0, 0, 3'b000, 1);
    step(0, 1, 3'b001, 0);
    step(0, 0, 3'b010, 0);
    step(0, 0, 3'b100, 0);
    step(0, 1, 3'b010, 0);
    check("en_gate_noerr", {err_onehot, err_seq, phase_valid}, 32'd1);

    // 6: five revolutions through the 2-bit counter
`ifdef RING_MON_REV_SAT_EN
    exp_rev = '{1, 2, 3, 3, 3};
`else
    exp_rev = '{1, 2, 3, 0, 1};
`endif
    step(0, 0, 3'b000, 1);
    step(0, 1, 3'b001, 0);
    tick_seen = 0;
    for (int r = 0; r < 5; r++) begin
      step(0, 1, 3'b010, 0);
      step(0, 1, 3'b100, 0);
      step(0, 1, 3'b001, 0);
      check("rev_seq", 32'(rev_count), 32'(exp_rev[r]));
    end
    check("tick_pulses", 32'(tick_seen), 32'd5);

    // randomized traffic against the model
    cur = 3'b001;
    for (int k = 0; k < 3000; k++) begin
      logic r, e, c;
      nxt = {cur[N-2:0], cur[N-1]};
      if ($urandom_range(0, 99) < 80) cur = nxt;
      else if ($urandom_range(0, 1) == 0) cur = 3'($urandom_range(0, 7));
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 99) < 80);
      c = ($urandom_range(0, 99) < 4);
      step(r, e, cur, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
